datapoint_buffer_reader: RTL and testbench

Streams a contiguous run of 16-bit datapoints out of the datapoint buffer memory, one word per transfer, toward the neuron datapath.
- Drives the memory's write-enable, address and write-data inputs, and consumes its read-data output.
- Hides the memory's fixed read latency behind a ready/valid output stream with a small credit-controlled FIFO, so back-pressure never loses or duplicates a word.
- Controlled by the control unit with a start/base/count command and a one-cycle done pulse.

---
 rtl/datapoint_buffer_reader_pkg.sv | 24 ++
 rtl/datapoint_buffer_reader_if.sv | 29 ++
 rtl/dp_sync_fifo.sv | 56 +++++
 rtl/datapoint_buffer_reader.sv | 121 ++++++++++++
 tb/tb_datapoint_buffer_reader.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/datapoint_buffer_reader_pkg.sv
// Shared definitions for the datapoint buffer accessors: default widths,
// reader FSM encoding and the memory-port bundle.
package datapoint_buffer_reader_pkg;

  localparam int DP_DATA_W = 16;
  localparam int DP_ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Request half of the datapoint buffer port; read data returns separately.
  typedef struct packed {
    logic                 wrEna;
    logic [DP_ADDR_W-1:0] Addr;
    logic [DP_DATA_W-1:0] dataIn;
  } mem_req_t;

  typedef logic [DP_DATA_W-1:0] mem_rsp_t;

endpackage

// File: rtl/datapoint_buffer_reader_if.sv
// Memory port plus ready/valid output stream of the datapoint buffer reader.
interface datapoint_buffer_reader_if
  import datapoint_buffer_reader_pkg::*;
#(
  parameter int DATA_W = DP_DATA_W,
  parameter int ADDR_W = DP_ADDR_W
) ();

  logic              mem_wrEna;
  logic [ADDR_W-1:0] mem_Addr;
  logic [DATA_W-1:0] mem_dataIn;
  logic [DATA_W-1:0] mem_rdData;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_bits;
  logic              out_last;

  modport master (
    output mem_wrEna, mem_Addr, mem_dataIn, out_valid, out_bits, out_last,
    input  mem_rdData, out_ready
  );

  modport slave (
    input  mem_wrEna, mem_Addr, mem_dataIn, out_valid, out_bits, out_last,
    output mem_rdData, out_ready
  );

endinterface

// File: rtl/dp_sync_fifo.sv
// Small synchronous FIFO with occupancy count; a push and a pop in the
// same cycle are both honoured, even when full.
module dp_sync_fifo #(
  parameter  int DATA_W     = 16,
  parameter  int FIFO_DEPTH = 2,
  localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop) rd_ptr <= bump(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // The reader's credit scheme must never push into a full FIFO without a pop.
  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(push && full && !pop));

endmodule

// File: rtl/datapoint_buffer_reader.sv
// Streams a contiguous run of datapoints from the buffer memory onto a
// ready/valid stream, hiding read latency behind a credit-controlled FIFO.
module datapoint_buffer_reader
  import datapoint_buffer_reader_pkg::*;
#(
  parameter int DATA_W     = DP_DATA_W,
  parameter int ADDR_W     = DP_ADDR_W,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_start,
  input  logic [ADDR_W-1:0]   io_base,
  input  logic [ADDR_W:0]     io_count,
  output logic                io_busy,
  output logic                io_done,
  datapoint_buffer_reader_if.master io
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   issued;
  logic [ADDR_W:0]   delivered;
  logic [RD_LAT-1:0] pipe;
  logic              issue;
  logic              xfer;
  logic              start_run;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_head;
  int                credit_used;

  assign xfer      = !fifo_empty && io.out_ready;
  assign start_run = (state == IDLE) && io_start && (io_count != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // A word popped this cycle frees its slot, which keeps full throughput.
  always_comb begin
    next_state  = state;
    io_busy     = 1'b0;
    io_done     = 1'b0;
    credit_used = int'(fifo_count) + $countones(pipe) - (xfer ? 1 : 0);
    issue       = (state == ISSUE) && (issued < count_q) && (credit_used < FIFO_DEPTH);
    case (state)
      IDLE: begin
        if (io_start) next_state = (io_count == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        io_busy = 1'b1;
        if (issued == count_q) next_state = DRAIN;
      end
      DRAIN: begin
        io_busy = 1'b1;
        if ((delivered == count_q) || (xfer && io.out_last)) next_state = DONE;
      end
      DONE: begin
        io_busy    = 1'b1;
        io_done    = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr    <= '0;
      count_q   <= '0;
      issued    <= '0;
      delivered <= '0;
      pipe      <= '0;
    end else begin
      pipe <= (pipe << 1) | RD_LAT'(issue);
      if (start_run) begin
        rd_ptr    <= io_base;
        count_q   <= io_count;
        issued    <= '0;
        delivered <= '0;
      end else begin
        if (issue) begin
          rd_ptr <= rd_ptr + 1'b1;
          issued <= issued + 1'b1;
        end
        if (xfer) delivered <= delivered + 1'b1;
      end
    end
  end

  dp_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (pipe[RD_LAT-1]),
    .push_data (io.mem_rdData),
    .pop       (xfer),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign io.mem_wrEna  = 1'b0;
  assign io.mem_dataIn = '0;
  assign io.mem_Addr   = rd_ptr;
  assign io.out_valid  = !fifo_empty;
  assign io.out_bits   = fifo_head;
  assign io.out_last   = !fifo_empty && (delivered == count_q - 1'b1);

endmodule

// File: tb/tb_datapoint_buffer_reader.sv
// Directed bench for datapoint_buffer_reader: memory model preloaded with
// mem[a]=a+100, scoreboard queue of expected beats filled at each start.
module tb_datapoint_buffer_reader;
  import datapoint_buffer_reader_pkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 2;

  typedef struct {
    logic [DATA_W-1:0] bits;
    logic              last;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              io_start;
  logic [ADDR_W-1:0] io_base;
  logic [ADDR_W:0]   io_count;
  logic              io_busy;
  logic              io_done;

  datapoint_buffer_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  datapoint_buffer_reader #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .RD_LAT     (1),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .io_start (io_start),
    .io_base  (io_base),
    .io_count (io_count),
    .io_busy  (io_busy),
    .io_done  (io_done),
    .io       (bus)
  );

  always #5 clock = ~clock;

  logic [DATA_W-1:0] mem_model [1 << ADDR_W];
  always @(posedge clock) bus.mem_rdData <= mem_model[bus.mem_Addr];

  exp_t              exp_q[$];
  int                vectors = 0;
  int                miscompares = 0;
  int                cyc = 0;
  int                beats_run = 0;
  int                first_xfer_cyc = 0;
  int                last_xfer_cyc = 0;
  int                done_cyc = 0;
  int                done_cnt = 0;
  int                max_lead = 0;
  int                done_before;
  logic [ADDR_W-1:0] run_base = '0;
  logic              toggle_mode = 1'b0;
  logic              ready_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One clock: inputs stable from posedge+1, outputs sampled at negedge.
  task automatic run_cycle();
    exp_t e;
    int   lead;
    if (toggle_mode) bus.out_ready = ready_pat[cyc % 6];
    @(negedge clock);
    cyc++;
    if (io_busy) begin
      lead = int'(ADDR_W'(bus.mem_Addr - run_base)) - beats_run;
      if (lead > max_lead) max_lead = lead;
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check_output("extra_beat", 32'(bus.out_bits), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_output("out_bits", 32'(bus.out_bits), 32'(e.bits));
        check_output("out_last", 32'(bus.out_last), 32'(e.last));
      end
      if (beats_run == 0) first_xfer_cyc = cyc;
      last_xfer_cyc = cyc;
      beats_run++;
    end
    if (io_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic apply_stimulus(input int base, input int count, input bit accept);
    if (accept) begin
      for (int i = 0; i < count; i++) begin
        exp_q.push_back('{bits: DATA_W'(((base + i) % (1 << ADDR_W)) + 100),
                          last: (i == count - 1)});
      end
      run_base  = ADDR_W'(base);
      beats_run = 0;
      max_lead  = 0;
    end
    io_start = 1'b1;
    io_base  = ADDR_W'(base);
    io_count = (ADDR_W + 1)'(count);
    run_cycle();
    io_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    int start_done;
    n = 0;
    start_done = done_cnt;
    while (done_cnt == start_done && n < budget) begin
      run_cycle();
      n++;
    end
    check_output("done_seen", 32'(done_cnt != start_done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    io_start     = 1'b0;
    io_base      = '0;
    io_count     = '0;
    bus.out_ready = 1'b0;
    for (int a = 0; a < (1 << ADDR_W); a++) mem_model[a] = DATA_W'(a + 100);

    #12;
    check_output("rst_busy",  32'(io_busy), 32'd0);
    check_output("rst_done",  32'(io_done), 32'd0);
    check_output("rst_valid", 32'(bus.out_valid), 32'd0);
    check_output("rst_last",  32'(bus.out_last), 32'd0);
    check_output("rst_addr",  32'(bus.mem_Addr), 32'd0);
    check_output("rst_bits",  32'(bus.out_bits), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    run_cycle();

    $display("[TB] run 1: base=5 count=4, ready held high");
    bus.out_ready = 1'b1;
    apply_stimulus(5, 4, 1'b1);
    wait_done(40);
    check_output("t1_beats",      32'(beats_run), 32'd4);
    check_output("t1_back2back",  32'(last_xfer_cyc - first_xfer_cyc), 32'd3);
    check_output("t1_done_delay", 32'(done_cyc - last_xfer_cyc), 32'd1);
    check_output("t1_busy_after", 32'(io_busy), 32'd0);
    check_output("t1_done_width", 32'(io_done), 32'd0);
    check_output("t1_queue_left", 32'(exp_q.size()), 32'd0);
    check_output("t1_wr_ena",     32'(bus.mem_wrEna), 32'd0);
    check_output("t1_data_in",    32'(bus.mem_dataIn), 32'd0);

    $display("[TB] run 2: base=5 count=4, ready toggling");
    toggle_mode = 1'b1;
    apply_stimulus(5, 4, 1'b1);
    wait_done(80);
    toggle_mode = 1'b0;
    bus.out_ready = 1'b1;
    check_output("t2_beats",      32'(beats_run), 32'd4);
    check_output("t2_queue_left", 32'(exp_q.size()), 32'd0);
    check_output("t2_addr_lead",  32'(max_lead <= DEPTH), 32'd1);

    $display("[TB] run 3: base=1022 count=4, address wrap");
    apply_stimulus(1022, 4, 1'b1);
    wait_done(40);
    check_output("t3_beats",      32'(beats_run), 32'd4);
    check_output("t3_queue_left", 32'(exp_q.size()), 32'd0);
    check_output("t3_addr_lead",  32'(max_lead <= DEPTH), 32'd1);

    $display("[TB] run 4: count=0");
    done_before = done_cnt;
    apply_stimulus(7, 0, 1'b1);
    check_output("t4_done_pulse", 32'(io_done), 32'd1);
    check_output("t4_busy_done",  32'(io_busy), 32'd1);
    check_output("t4_no_valid",   32'(bus.out_valid), 32'd0);
    run_cycle();
    check_output("t4_done_once",  32'(done_cnt - done_before), 32'd1);
    check_output("t4_busy_after", 32'(io_busy), 32'd0);
    check_output("t4_no_beats",   32'(beats_run), 32'd0);

    $display("[TB] run 5: start while busy is ignored");
    apply_stimulus(10, 3, 1'b1);
    run_cycle();
    apply_stimulus(0, 2, 1'b0);
    wait_done(40);
    check_output("t5_beats",      32'(beats_run), 32'd3);
    check_output("t5_queue_left", 32'(exp_q.size()), 32'd0);
    apply_stimulus(0, 2, 1'b1);
    wait_done(40);
    check_output("t5_next_beats", 32'(beats_run), 32'd2);
    check_output("t5_next_queue", 32'(exp_q.size()), 32'd0);

    $display("[TB] run 6: asynchronous reset mid-run");
    bus.out_ready = 1'b0;
    apply_stimulus(20, 6, 1'b1);
    for (int i = 0; i < 4; i++) run_cycle();
    check_output("t6_buffered",   32'(bus.out_valid), 32'd1);
    check_output("t6_head",       32'(bus.out_bits), 32'd120);
    done_before = done_cnt;
    #2;
    reset = 1'b1;
    #1;
    check_output("t6_rst_valid",  32'(bus.out_valid), 32'd0);
    check_output("t6_rst_busy",   32'(io_busy), 32'd0);
    exp_q.delete();
    run_cycle();
    run_cycle();
    reset = 1'b0;
    beats_run = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) run_cycle();
    check_output("t6_no_done",    32'(done_cnt - done_before), 32'd0);
    check_output("t6_no_beats",   32'(beats_run), 32'd0);
    apply_stimulus(0, 1, 1'b1);
    wait_done(40);
    check_output("t6_after_beats", 32'(beats_run), 32'd1);
    check_output("t6_after_queue", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
